// File: rtl/tc_bus_master.sv
// tc_bus_master: queued register-bus initiator with autonomous interrupt service
module tc_bus_master #(
  parameter int         DEPTH     = 4,
  parameter int         RD_LAT    = 1,
  parameter logic [7:0] FLAG_ADDR = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic [7:0] addr,
  output logic       write,
  output logic [7:0] wdata,
  output logic       read,
  input  logic [7:0] rdata,
  input  logic       interrupt_request,
  output logic       irq_valid,
  output logic [7:0] irq_flags,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, IRQ_RD, IRQ_WAIT, IRQ_CLR} state_t;
  state_t state, state_n;
  logic [16:0] mem [DEPTH];
  logic [16:0] head;
  logic [AW:0] wp, rp;
  logic empty, full, push, pop, svc, irq_q, irq_pend;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] addr_n, wdata_n, rsp_addr_n, rsp_data_n, irq_flags_n;
  logic write_n, read_n, rsp_valid_n, irq_valid_n;
  assign empty     = wp == rp;
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rp[AW-1:0]];
  assign busy      = (state != IDLE) || !empty || irq_pend;
  // command storage; entries are {write, addr, wdata}
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  // FIFO pointers and interrupt edge capture; a new edge wins over the service clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      irq_q    <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      wp       <= wp + {{AW{1'b0}}, push};
      rp       <= rp + {{AW{1'b0}}, pop};
      irq_q    <= interrupt_request;
      irq_pend <= (interrupt_request && !irq_q) || (irq_pend && !svc);
    end
  // state and registered bus/response outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      wdata     <= '0;
      write     <= 1'b0;
      read      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      irq_valid <= 1'b0;
      irq_flags <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      write     <= write_n;
      read      <= read_n;
      rsp_valid <= rsp_valid_n;
      rsp_addr  <= rsp_addr_n;
      rsp_data  <= rsp_data_n;
      irq_valid <= irq_valid_n;
      irq_flags <= irq_flags_n;
    end
  // next state; interrupt service only launches from IDLE and outranks queued commands
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr;
    wdata_n     = wdata;
    write_n     = 1'b0;
    read_n      = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_addr_n  = rsp_addr;
    rsp_data_n  = rsp_data;
    irq_valid_n = 1'b0;
    irq_flags_n = irq_flags;
    pop         = 1'b0;
    svc         = 1'b0;
    case (state)
      IDLE:
        if (irq_pend) begin
          svc     = 1'b1;
          read_n  = 1'b1;
          addr_n  = FLAG_ADDR;
          state_n = IRQ_RD;
        end else if (!empty) begin
          pop     = 1'b1;
          addr_n  = head[15:8];
          write_n = head[16];
          read_n  = !head[16];
          wdata_n = head[16] ? head[7:0] : wdata;
          state_n = head[16] ? WR : RD;
        end
      WR, IRQ_CLR: state_n = IDLE;
      RD: begin
        cnt_n   = CW'(RD_LAT - 1);
        state_n = RWAIT;
      end
      IRQ_RD: begin
        cnt_n   = CW'(RD_LAT - 1);
        state_n = IRQ_WAIT;
      end
      RWAIT:
        if (cnt == '0) begin
          rsp_valid_n = 1'b1;
          rsp_addr_n  = addr;
          rsp_data_n  = rdata;
          state_n     = IDLE;
        end else cnt_n = cnt - CW'(1);
      IRQ_WAIT:
        if (cnt == '0) begin
          irq_flags_n = rdata;
          write_n     = rdata != 8'h00;
          wdata_n     = rdata != 8'h00 ? rdata : wdata;
          irq_valid_n = rdata != 8'h00;
          state_n     = rdata != 8'h00 ? IRQ_CLR : IDLE;
        end else cnt_n = cnt - CW'(1);
      default: state_n = IDLE;
    endcase
  end
endmodule
